// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared types and helpers for the AXIS round-robin arbiter.
// Contents: arb_state_t FSM encoding, idx_w() grant-index width helper.
package axis_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Width of a source index; never below 1 so NUM_S=1 still has a port.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_pick.sv
// rr_arb_pick: combinational round-robin pick of the next requester after last.
// Ports: req[NUM_S] requests, last previous winner -> any, idx winner.
module rr_arb_pick
  import axis_arb_pkg::*;
#(
  parameter  int NUM_S = 4,
  localparam int IDX_W = idx_w(NUM_S)
) (
  input  logic [NUM_S-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int w_best_d;
  int w_d;

  // Distance of source i from last+1, wrapped explicitly modulo NUM_S.
  // The requester with the smallest distance wins.
  always_comb begin
    w_best_d = NUM_S;
    w_d      = 0;
    idx      = '0;
    for (int i = 0; i < NUM_S; i++) begin
      w_d = i - int'(last) - 1;
      if (w_d < 0) begin
        w_d = w_d + NUM_S;
      end
      if (req[i] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        idx      = IDX_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin AXI4-Stream arbiter/mux.
// Ports: aclk, areset_n; s_* (NUM_S sources); m_* (one sink); m_tid with AXIS_ARB_TID_EN.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_S      = 4,
  parameter  int DATA_WIDTH = 8,
  localparam int KEEP_W     = DATA_WIDTH / 8,
  localparam int IDX_W      = idx_w(NUM_S)
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic [NUM_S-1:0]             s_tvalid,
  output logic [NUM_S-1:0]             s_tready,
  input  logic [NUM_S*DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_S*KEEP_W-1:0]      s_tkeep,
  input  logic [NUM_S-1:0]             s_tlast,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic [KEEP_W-1:0]            m_tkeep,
  output logic                         m_tlast
`ifdef AXIS_ARB_TID_EN
  ,
  output logic [IDX_W-1:0]             m_tid
`endif
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_grant_nxt;
  logic [IDX_W-1:0] w_last_nxt;

  logic             w_pick_any;
  logic [IDX_W-1:0] w_pick_idx;

  logic                  w_busy;
  logic                  w_eop;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [KEEP_W-1:0]     w_sel_keep;

  rr_arb_pick #(
    .NUM_S (NUM_S)
  ) u_pick (
    .req  (s_tvalid),
    .last (r_last),
    .any  (w_pick_any),
    .idx  (w_pick_idx)
  );

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_S - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = ARB_BUSY;
          w_grant_nxt = w_pick_idx;
        end
      end
      ARB_BUSY: begin
        if (w_eop) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = r_grant;
        end
      end
    endcase
  end

  // Source mux follows r_grant in every state, so reset shows source 0.
  always_comb begin
    w_sel_valid = s_tvalid[0];
    w_sel_last  = s_tlast[0];
    w_sel_data  = s_tdata[0 +: DATA_WIDTH];
    w_sel_keep  = s_tkeep[0 +: KEEP_W];
    for (int i = 0; i < NUM_S; i++) begin
      if (r_grant == IDX_W'(i)) begin
        w_sel_valid = s_tvalid[i];
        w_sel_last  = s_tlast[i];
        w_sel_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_keep  = s_tkeep[i*KEEP_W +: KEEP_W];
      end
    end
  end

  always_comb begin
    w_busy   = (r_state == ARB_BUSY);
    m_tvalid = w_busy & w_sel_valid;
    m_tdata  = w_sel_data;
    m_tkeep  = w_sel_keep;
    m_tlast  = w_sel_last;
    s_tready = '0;
    for (int i = 0; i < NUM_S; i++) begin
      s_tready[i] = w_busy & m_tready & (r_grant == IDX_W'(i));
    end
    w_eop = m_tvalid & m_tready & w_sel_last;
  end

`ifdef AXIS_ARB_TID_EN
  assign m_tid = w_busy ? r_grant : '0;
`endif

endmodule
